// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: ALU op codes, LSU FSM states, bus size codes,
// and op-class helpers used by the load/store unit.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_ADDR  = 3'd1,
    LSU_DATA  = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational store lane/strobe formatting, alignment check and load extension.
// Zero latency; no handshake.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        ld_op,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_mem,
  output logic              is_load,
  output logic              fault,
  output logic [1:0]        size,
  output logic [DATA_W-1:0] st_wdata,
  output logic [3:0]        st_wstrb,
  output logic [DATA_W-1:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_mem   = 1'b1;
    is_load  = 1'b0;
    fault    = 1'b0;
    size     = SIZE_BYTE;
    st_wdata = '0;
    st_wstrb = 4'b0000;
    case (op)
      EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
      EXE_LH_OP, EXE_LHU_OP: begin
        is_load = 1'b1;
        size    = SIZE_HALF;
        fault   = addr_lo[0];
      end
      EXE_LW_OP: begin
        is_load = 1'b1;
        size    = SIZE_WORD;
        fault   = |addr_lo;
      end
      EXE_SB_OP: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr_lo;
      end
      EXE_SH_OP: begin
        size     = SIZE_HALF;
        fault    = addr_lo[0];
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      EXE_SW_OP: begin
        size     = SIZE_WORD;
        fault    = |addr_lo;
        st_wdata = wdata;
        st_wstrb = 4'b1111;
      end
      default: is_mem = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      EXE_LB_OP:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: ld_result = {24'd0, ld_byte};
      EXE_LH_OP:  ld_result = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: ld_result = {16'd0, ld_half};
      default:    ld_result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a split addr/data bus; one access in flight.
// Result 3+ cycles after request; stall_lsu holds the pipe until the bus completes.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [7:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] wdata_in,
  input  logic              flush,
  input  logic              pipe_adv,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [ADDR_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] load_result,
  output logic              stall_lsu,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  lsu_state_e        state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        size_q, size_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] result_q, result_d;

  logic              is_mem, is_load, fault, issue;
  logic [1:0]        fmt_size;
  logic [ADDR_W-1:0] fmt_wdata, ld_result;
  logic [3:0]        fmt_wstrb;

  mem_align u_align (
    .op        (op),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata_in),
    .ld_op     (op_q),
    .ld_off    (addr_q[1:0]),
    .rdata     (data_rdata),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .fault     (fault),
    .size      (fmt_size),
    .st_wdata  (fmt_wdata),
    .st_wstrb  (fmt_wstrb),
    .ld_result (ld_result)
  );

  assign issue = req_valid && is_mem && !fault && !flush;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    wr_d      = wr_q;
    result_d  = result_q;
    data_req  = 1'b0;
    stall_lsu = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (issue) begin
          stall_lsu = 1'b1;
          state_d   = LSU_ADDR;
          op_d      = op;
          addr_d    = addr;
          wdata_d   = fmt_wdata;
          wstrb_d   = fmt_wstrb;
          size_d    = fmt_size;
          wr_d      = !is_load;
        end
      end
      LSU_ADDR: begin
        data_req  = 1'b1;
        stall_lsu = 1'b1;
        // An accepted address still owes a data beat, so a flush must drain it.
        if (data_addr_ok) state_d = flush ? LSU_DRAIN : LSU_DATA;
        else if (flush)   state_d = LSU_IDLE;
      end
      LSU_DATA: begin
        stall_lsu = 1'b1;
        if (flush) begin
          state_d = data_data_ok ? LSU_IDLE : LSU_DRAIN;
        end else if (data_data_ok) begin
          if (is_load_op(op_q)) result_d = ld_result;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (pipe_adv || flush) state_d = LSU_IDLE;
      end
      LSU_DRAIN: begin
        stall_lsu = issue;
        if (data_data_ok) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      result_q <= result_d;
    end
  end

  assign data_wr     = wr_q;
  assign data_size   = size_q;
  assign data_addr   = addr_q;
  assign data_wdata  = wdata_q;
  assign data_wstrb  = wstrb_q;
  assign load_result = result_q;

  assign adel     = req_valid && is_load && fault && !flush;
  assign ades     = req_valid && is_mem && !is_load && fault && !flush;
  assign badvaddr = (adel || ades) ? addr : '0;

endmodule
